reg_file_multiport: RTL and testbench

// - Parametrised register file for the RV32 datapath: NUM_RD synchronous read ports, one write port.
// - Built-in clear sequencer zeroes every entry after reset, so the array itself needs no reset.
// - Sits between decode (read addresses) and writeback (write port); replaces the fixed 2R1W file.

---
 rtl/reg_file_multiport.sv | 84 ++++++++
 tb/tb_reg_file_multiport.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reg_file_multiport.sv
// Multi-read, single-write register file with a self-clearing sequencer after reset.
// Define RF_BYPASS_EN for write-through forwarding; otherwise reads see the old contents.
module reg_file_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     sysCLK,
    input  logic                     resetN,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdData_o,
    input  logic                     wrEn_i,
    input  logic [ADDR_W-1:0]        wrAddr_i,
    input  logic [DATA_W-1:0]        wrData_i,
    output logic                     busy_o
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        clrCnt_q, clrCnt_d;
    logic [NUM_RD*DATA_W-1:0] rdData_q, rdData_d;
    logic [DATA_W-1:0]        mem [DEPTH];

    always_ff @(posedge sysCLK or negedge resetN) begin
        if (!resetN) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
            rdData_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
            rdData_q <= rdData_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        case (state_q)
            CLEAR: begin
                if (clrCnt_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end else begin
                    clrCnt_d = clrCnt_q + 1'b1;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // The array has no reset; the clear sequencer owns it until READY.
    always_ff @(posedge sysCLK) begin
        if (state_q == CLEAR) begin
            mem[clrCnt_q] <= '0;
        end else if (wrEn_i && (wrAddr_i != '0)) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    always_comb begin
        rdData_d = '0;
        if (state_q == READY) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rdAddr_i[i*ADDR_W +: ADDR_W] == '0) begin
                    rdData_d[i*DATA_W +: DATA_W] = '0;
`ifdef RF_BYPASS_EN
                end else if (wrEn_i && (wrAddr_i == rdAddr_i[i*ADDR_W +: ADDR_W])) begin
                    rdData_d[i*DATA_W +: DATA_W] = wrData_i;
`endif
                end else begin
                    rdData_d[i*DATA_W +: DATA_W] = mem[rdAddr_i[i*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign rdData_o = rdData_q;
    assign busy_o   = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed-vector bench for reg_file_multiport (DATA_W=32, ADDR_W=5, NUM_RD=2).
module tb_reg_file_multiport;

    logic        sysCLK;
    logic        resetN;
    logic [9:0]  rdAddr;
    logic [63:0] rdData;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic        busy;

    int totalCount;
    int badCount;
    int busyCycles;

    reg_file_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .sysCLK  (sysCLK),
        .resetN  (resetN),
        .rdAddr_i(rdAddr),
        .rdData_o(rdData),
        .wrEn_i  (wrEn),
        .wrAddr_i(wrAddr),
        .wrData_i(wrData),
        .busy_o  (busy)
    );

    initial sysCLK = 1'b0;
    always #5 sysCLK = ~sysCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        if (observed !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [4:0] rd0, input logic [4:0] rd1,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        rdAddr = {rd1, rd0};
        wrEn   = we;
        wrAddr = wa;
        wrData = wd;
        @(posedge sysCLK);
        #1;
    endtask

    // Counts cycles until busy drops; optionally pulses a write at clear cycle 10.
    task automatic runClear(input logic pulseWrite);
        busyCycles = 0;
        while (busy && busyCycles < 40) begin
            wrEn   = pulseWrite && (busyCycles == 10);
            wrAddr = 5'd3;
            wrData = 32'hAA;
            @(posedge sysCLK);
            #1;
            busyCycles++;
        end
        wrEn = 1'b0;
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        resetN = 1'b0;
        rdAddr = '0;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;

        repeat (2) @(posedge sysCLK);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd1);
        checkOutput("reset rd0", rdData[31:0], 32'd0);
        checkOutput("reset rd1", rdData[63:32], 32'd0);
        resetN = 1'b1;

        runClear(1'b1);
        checkOutput("clear length", busyCycles, 32'd32);
        checkOutput("busy after clear", {31'd0, busy}, 32'd0);

        for (int a = 0; a < 32; a += 2) begin
            applyStimulus(5'(a), 5'(a + 1), 1'b0, 5'd0, 32'd0);
            checkOutput($sformatf("cleared addr %0d", a), rdData[31:0], 32'd0);
            checkOutput($sformatf("cleared addr %0d", a + 1), rdData[63:32], 32'd0);
        end

        applyStimulus(5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
        checkOutput("write in clear dropped", rdData[31:0], 32'd0);

        applyStimulus(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
        checkOutput("addr5 port0", rdData[31:0], 32'hDEADBEEF);
        checkOutput("addr5 port1", rdData[63:32], 32'hDEADBEEF);

        applyStimulus(5'd0, 5'd0, 1'b1, 5'd10, 32'hA5A5_5A5A);
        applyStimulus(5'd10, 5'd5, 1'b0, 5'd0, 32'd0);
        checkOutput("indep port0 addr10", rdData[31:0], 32'hA5A5_5A5A);
        checkOutput("indep port1 addr5", rdData[63:32], 32'hDEADBEEF);

        applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678);
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("addr0 port0", rdData[31:0], 32'd0);
        checkOutput("addr0 port1", rdData[63:32], 32'd0);

        applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678);
        checkOutput("addr0 same-cycle", rdData[31:0], 32'd0);

        applyStimulus(5'd0, 5'd0, 1'b1, 5'd7, 32'h11);
        applyStimulus(5'd7, 5'd7, 1'b1, 5'd7, 32'h22);
`ifdef RF_BYPASS_EN
        checkOutput("rw same addr7 p0", rdData[31:0], 32'h22);
        checkOutput("rw same addr7 p1", rdData[63:32], 32'h22);
`else
        checkOutput("rw same addr7 p0", rdData[31:0], 32'h11);
        checkOutput("rw same addr7 p1", rdData[63:32], 32'h11);
`endif
        applyStimulus(5'd7, 5'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("addr7 next read", rdData[31:0], 32'h22);

        applyStimulus(5'd0, 5'd0, 1'b1, 5'd9, 32'h55);
        applyStimulus(5'd9, 5'd9, 1'b0, 5'd0, 32'd0);
        checkOutput("addr9 before reset", rdData[31:0], 32'h55);

        resetN = 1'b0;
        #2;
        checkOutput("async reset busy", {31'd0, busy}, 32'd1);
        checkOutput("async reset rd0", rdData[31:0], 32'd0);
        checkOutput("async reset rd1", rdData[63:32], 32'd0);
        @(posedge sysCLK);
        #1;
        resetN = 1'b1;

        runClear(1'b0);
        checkOutput("reclear length", busyCycles, 32'd32);
        applyStimulus(5'd9, 5'd5, 1'b0, 5'd0, 32'd0);
        checkOutput("addr9 after reclear", rdData[31:0], 32'd0);
        checkOutput("addr5 after reclear", rdData[63:32], 32'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
